// File: rtl/cache_axi_arb.sv
// ---------------------------------------------------------------------------
// cache_axi_arb
//
// Merges NCH cache-side AXI-io request ports onto the single AXI-io port of
// the AXI bridge. One channel is granted per downstream transaction. Its
// request fields are captured at grant time and held until the bridge signals
// completion. The completion pulse is then routed back only to that channel.
//
// Transaction timing:
//   IDLE  : arbitrate; a winner is captured on the next edge.
//   BUSY  : downstream request is held until i_axi_io_ready.
//   DRAIN : one cycle with no arbitration, so the finished requester has
//           time to drop its valid before the next arbitration.
//
// Ports:
//   clk, rst            clock; synchronous active-low reset
//   i_ch_valid/op       per-channel request valid and op (0 = read, 1 = write)
//   i_ch_wdata/addr/
//   i_ch_size/blks      flattened per-channel request fields; channel k
//                       occupies slice [k*W +: W]
//   o_ch_ready          per-channel completion pulse (granted channel only)
//   o_ch_rdata          read data, broadcast to every channel
//   o_axi_io_*          downstream request to the bridge
//   i_axi_io_ready      downstream completion pulse; rdata valid in that cycle
//   i_axi_io_rdata      downstream read data
//   o_grant             one-hot current grant; zero when idle
// ---------------------------------------------------------------------------
module cache_axi_arb #(
    parameter int NCH     = 2,
    parameter int DATA_W  = 512,
    parameter int ADDR_W  = 64,
    parameter int RR_MODE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NCH-1:0]        i_ch_valid,
    input  logic [NCH-1:0]        i_ch_op,
    input  logic [NCH*DATA_W-1:0] i_ch_wdata,
    input  logic [NCH*ADDR_W-1:0] i_ch_addr,
    input  logic [NCH*2-1:0]      i_ch_size,
    input  logic [NCH*8-1:0]      i_ch_blks,
    output logic [NCH-1:0]        o_ch_ready,
    output logic [DATA_W-1:0]     o_ch_rdata,
    output logic                  o_axi_io_valid,
    output logic                  o_axi_io_op,
    output logic [DATA_W-1:0]     o_axi_io_wdata,
    output logic [ADDR_W-1:0]     o_axi_io_addr,
    output logic [1:0]            o_axi_io_size,
    output logic [7:0]            o_axi_io_blks,
    input  logic                  i_axi_io_ready,
    input  logic [DATA_W-1:0]     i_axi_io_rdata,
    output logic [NCH-1:0]        o_grant
);

    // Keep the index at least one bit wide so NCH = 1 still elaborates.
    localparam int PTR_W = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BUSY  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]       state;
    logic [PTR_W-1:0] rr_ptr;    // last channel served
    logic [PTR_W-1:0] gnt_idx;   // binary form of o_grant

    logic             win_found;
    logic [PTR_W-1:0] win_idx;
    logic [NCH-1:0]   win_oh;
    logic [PTR_W-1:0] cand;

    // ------------------------------------------------------------------
    // Winner selection.
    // Round-robin scans upward from the channel after the last one served,
    // wrapping around. The first request found wins. Fixed priority takes
    // the lowest requesting index.
    // ------------------------------------------------------------------
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_oh    = '0;
        cand      = '0;
        if (RR_MODE != 0) begin
            for (int i = 1; i <= NCH; i++) begin
                cand = PTR_W'((int'(rr_ptr) + i) % NCH);
                if (!win_found && i_ch_valid[cand]) begin
                    win_found = 1'b1;
                    win_idx   = cand;
                end
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                cand = PTR_W'(i);
                if (!win_found && i_ch_valid[cand]) begin
                    win_found = 1'b1;
                    win_idx   = cand;
                end
            end
        end
        if (win_found)
            win_oh[win_idx] = 1'b1;
    end

    // ------------------------------------------------------------------
    // Transaction FSM and downstream request registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= S_IDLE;
            rr_ptr         <= PTR_W'(NCH - 1);   // channel 0 is checked first
            gnt_idx        <= '0;
            o_grant        <= '0;
            o_axi_io_valid <= 1'b0;
            o_axi_io_op    <= 1'b0;
            o_axi_io_wdata <= '0;
            o_axi_io_addr  <= '0;
            o_axi_io_size  <= '0;
            o_axi_io_blks  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (win_found) begin
                        // Fields are sampled only here. After this edge the
                        // requester may change them without affecting the
                        // transaction in flight.
                        o_axi_io_op    <= i_ch_op[win_idx];
                        o_axi_io_wdata <= i_ch_wdata[win_idx*DATA_W +: DATA_W];
                        o_axi_io_addr  <= i_ch_addr[win_idx*ADDR_W +: ADDR_W];
                        o_axi_io_size  <= i_ch_size[win_idx*2 +: 2];
                        o_axi_io_blks  <= i_ch_blks[win_idx*8 +: 8];
                        o_axi_io_valid <= 1'b1;
                        o_grant        <= win_oh;
                        gnt_idx        <= win_idx;
                        state          <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    // The requester cannot abort. The transaction runs to
                    // completion even if its valid drops.
                    if (i_axi_io_ready) begin
                        o_axi_io_valid <= 1'b0;
                        rr_ptr         <= gnt_idx;
                        state          <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    o_grant <= '0;
                    state   <= S_IDLE;
                end
                default: begin
                    o_grant        <= '0;
                    o_axi_io_valid <= 1'b0;
                    state          <= S_IDLE;
                end
            endcase
        end
    end

    // Completion is routed back only while a transaction is outstanding.
    // A ready pulse in IDLE or DRAIN is dropped.
    assign o_ch_ready = (state == S_BUSY && i_axi_io_ready) ? o_grant : '0;
    assign o_ch_rdata = i_axi_io_rdata;

endmodule

// File: tb/tb_cache_axi_arb.sv
// ---------------------------------------------------------------------------
// tb_cache_axi_arb
//
// Directed bench for cache_axi_arb with two channels. A round-robin instance
// and a fixed-priority instance share all inputs. Each scenario task drives
// stimulus on posedge+1 and checks its expected values inline.
// ---------------------------------------------------------------------------
module tb_cache_axi_arb;

    localparam int NCH = 2;
    localparam int DW  = 512;
    localparam int AW  = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic [NCH-1:0]      ch_valid, ch_op;
    logic [NCH*DW-1:0]   ch_wdata;
    logic [NCH*AW-1:0]   ch_addr;
    logic [NCH*2-1:0]    ch_size;
    logic [NCH*8-1:0]    ch_blks;
    logic                axi_ready;
    logic [DW-1:0]       axi_rdata;

    logic [NCH-1:0] r_ch_ready, r_grant, f_ch_ready, f_grant;
    logic [DW-1:0]  r_ch_rdata, r_wdata, f_ch_rdata, f_wdata;
    logic           r_valid, r_op, f_valid, f_op;
    logic [AW-1:0]  r_addr, f_addr;
    logic [1:0]     r_size, f_size;
    logic [7:0]     r_blks, f_blks;

    int errors = 0;
    int checks = 0;

    cache_axi_arb #(.NCH(NCH), .DATA_W(DW), .ADDR_W(AW), .RR_MODE(1)) dut_rr (
        .clk(clk), .rst(rst),
        .i_ch_valid(ch_valid), .i_ch_op(ch_op), .i_ch_wdata(ch_wdata),
        .i_ch_addr(ch_addr), .i_ch_size(ch_size), .i_ch_blks(ch_blks),
        .o_ch_ready(r_ch_ready), .o_ch_rdata(r_ch_rdata),
        .o_axi_io_valid(r_valid), .o_axi_io_op(r_op), .o_axi_io_wdata(r_wdata),
        .o_axi_io_addr(r_addr), .o_axi_io_size(r_size), .o_axi_io_blks(r_blks),
        .i_axi_io_ready(axi_ready), .i_axi_io_rdata(axi_rdata),
        .o_grant(r_grant)
    );

    cache_axi_arb #(.NCH(NCH), .DATA_W(DW), .ADDR_W(AW), .RR_MODE(0)) dut_fp (
        .clk(clk), .rst(rst),
        .i_ch_valid(ch_valid), .i_ch_op(ch_op), .i_ch_wdata(ch_wdata),
        .i_ch_addr(ch_addr), .i_ch_size(ch_size), .i_ch_blks(ch_blks),
        .o_ch_ready(f_ch_ready), .o_ch_rdata(f_ch_rdata),
        .o_axi_io_valid(f_valid), .o_axi_io_op(f_op), .o_axi_io_wdata(f_wdata),
        .o_axi_io_addr(f_addr), .o_axi_io_size(f_size), .o_axi_io_blks(f_blks),
        .i_axi_io_ready(axi_ready), .i_axi_io_rdata(axi_rdata),
        .o_grant(f_grant)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        ch_valid  = '0;
        ch_op     = '0;
        ch_wdata  = '0;
        ch_addr   = '0;
        ch_size   = '0;
        ch_blks   = '0;
        axi_ready = 1'b0;
        axi_rdata = '0;
    endtask

    task automatic do_reset;
        clear_inputs();
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset;
        clear_inputs();
        ch_addr = {64'hFFFF_0000, 64'h1234_5678};
        rst = 1'b0;
        step();
        step();
        checks++; if (r_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0h exp=0", r_valid); end
        checks++; if (r_grant !== 2'b00) begin errors++; $display("FAIL reset_grant got=%0b exp=00", r_grant); end
        checks++; if (r_addr !== 64'h0) begin errors++; $display("FAIL reset_addr got=%0h exp=0", r_addr); end
        checks++; if (f_valid !== 1'b0) begin errors++; $display("FAIL reset_fp_valid got=%0h exp=0", f_valid); end
        rst = 1'b1;
        clear_inputs();
    endtask

    task automatic test_single_read;
        do_reset();
        ch_addr[1*AW +: AW] = 64'h8000_0040;
        ch_op[1] = 1'b0;
        ch_blks[8 +: 8] = 8'd0;
        ch_valid = 2'b10;
        #1;
        checks++; if (r_valid !== 1'b0) begin errors++; $display("FAIL rd_valid_t0 got=%0h exp=0", r_valid); end
        step();
        checks++; if (r_valid !== 1'b1) begin errors++; $display("FAIL rd_valid_t1 got=%0h exp=1", r_valid); end
        checks++; if (r_addr !== 64'h8000_0040) begin errors++; $display("FAIL rd_addr got=%0h exp=80000040", r_addr); end
        checks++; if (r_grant !== 2'b10) begin errors++; $display("FAIL rd_grant got=%0b exp=10", r_grant); end
        checks++; if (r_op !== 1'b0) begin errors++; $display("FAIL rd_op got=%0h exp=0", r_op); end
        axi_ready = 1'b1;
        axi_rdata = {64{8'hA5}};
        #1;
        checks++; if (r_ch_ready !== 2'b10) begin errors++; $display("FAIL rd_ch_ready got=%0b exp=10", r_ch_ready); end
        checks++; if (r_ch_rdata !== {64{8'hA5}}) begin errors++; $display("FAIL rd_rdata got=%0h exp=a5..a5", r_ch_rdata); end
        step();
        axi_ready = 1'b0;
        ch_valid = 2'b00;
        checks++; if (r_valid !== 1'b0) begin errors++; $display("FAIL rd_valid_drop got=%0h exp=0", r_valid); end
        checks++; if (r_grant !== 2'b10) begin errors++; $display("FAIL rd_grant_drain got=%0b exp=10", r_grant); end
        step();
        checks++; if (r_grant !== 2'b00) begin errors++; $display("FAIL rd_grant_idle got=%0b exp=00", r_grant); end
    endtask

    task automatic test_field_latch;
        do_reset();
        ch_addr[0 +: AW] = 64'h1000;
        ch_op[0] = 1'b1;
        ch_wdata[0 +: DW] = {16{32'hDEAD_BEEF}};
        ch_size[1:0] = 2'd3;
        ch_blks[7:0] = 8'd7;
        ch_valid = 2'b01;
        step();
        checks++; if (r_addr !== 64'h1000) begin errors++; $display("FAIL fl_addr got=%0h exp=1000", r_addr); end
        checks++; if (r_op !== 1'b1) begin errors++; $display("FAIL fl_op got=%0h exp=1", r_op); end
        checks++; if (r_wdata !== {16{32'hDEAD_BEEF}}) begin errors++; $display("FAIL fl_wdata got=%0h exp=deadbeef..", r_wdata); end
        checks++; if (r_size !== 2'd3 || r_blks !== 8'd7) begin errors++; $display("FAIL fl_size_blks got=%0h/%0h exp=3/7", r_size, r_blks); end
        // Change the request and drop valid while BUSY; the transaction must hold.
        ch_addr[0 +: AW] = 64'h2000;
        ch_op[0] = 1'b0;
        ch_valid = 2'b00;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++; if (r_addr !== 64'h1000 || r_valid !== 1'b1) begin errors++; $display("FAIL fl_hold%0d got=%0h/%0h exp=1000/1", c, r_addr, r_valid); end
        end
        axi_ready = 1'b1;
        #1;
        checks++; if (r_ch_ready !== 2'b01) begin errors++; $display("FAIL fl_ch_ready got=%0b exp=01", r_ch_ready); end
        step();
        axi_ready = 1'b0;
        step();
    endtask

    task automatic test_rr_contention;
        logic [1:0] exp_g;
        do_reset();
        ch_addr = {64'h200, 64'h100};
        ch_valid = 2'b11;
        for (int t = 0; t < 4; t++) begin
            exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
            step();
            checks++; if (r_grant !== exp_g) begin errors++; $display("FAIL rr_grant%0d got=%0b exp=%0b", t, r_grant, exp_g); end
            checks++; if (r_addr !== ((t % 2 == 0) ? 64'h100 : 64'h200)) begin errors++; $display("FAIL rr_addr%0d got=%0h", t, r_addr); end
            axi_ready = 1'b1;
            #1;
            checks++; if (r_ch_ready !== exp_g) begin errors++; $display("FAIL rr_ready%0d got=%0b exp=%0b", t, r_ch_ready, exp_g); end
            step();
            axi_ready = 1'b0;
            checks++; if (r_valid !== 1'b0) begin errors++; $display("FAIL rr_gap1_%0d got=%0h exp=0", t, r_valid); end
            step();
            checks++; if (r_valid !== 1'b0) begin errors++; $display("FAIL rr_gap2_%0d got=%0h exp=0", t, r_valid); end
        end
        ch_valid = 2'b00;
        step();
    endtask

    task automatic test_fp_starvation;
        do_reset();
        ch_valid = 2'b11;
        for (int t = 0; t < 3; t++) begin
            step();
            checks++; if (f_grant !== 2'b01) begin errors++; $display("FAIL fp_grant%0d got=%0b exp=01", t, f_grant); end
            axi_ready = 1'b1;
            #1;
            checks++; if (f_ch_ready !== 2'b01) begin errors++; $display("FAIL fp_ready%0d got=%0b exp=01", t, f_ch_ready); end
            step();
            axi_ready = 1'b0;
            if (t == 2) ch_valid = 2'b10;
            step();
        end
        step();
        checks++; if (f_grant !== 2'b10 || f_valid !== 1'b1) begin errors++; $display("FAIL fp_ch1_grant got=%0b/%0h exp=10/1", f_grant, f_valid); end
        axi_ready = 1'b1;
        step();
        axi_ready = 1'b0;
        ch_valid = 2'b00;
        step();
    endtask

    task automatic test_spurious_ready;
        do_reset();
        axi_ready = 1'b1;
        axi_rdata = {16{32'h5A5A_5A5A}};
        #1;
        checks++; if (r_ch_ready !== 2'b00 || f_ch_ready !== 2'b00) begin errors++; $display("FAIL sp_idle_ready got=%0b/%0b exp=00", r_ch_ready, f_ch_ready); end
        step();
        axi_ready = 1'b0;
        checks++; if (r_valid !== 1'b0 || r_grant !== 2'b00) begin errors++; $display("FAIL sp_state got=%0h/%0b exp=0/00", r_valid, r_grant); end
        // Still IDLE: a new request is accepted on the next edge.
        ch_addr[1*AW +: AW] = 64'h300;
        ch_valid = 2'b10;
        step();
        checks++; if (r_valid !== 1'b1 || r_grant !== 2'b10) begin errors++; $display("FAIL sp_accept got=%0h/%0b exp=1/10", r_valid, r_grant); end
        axi_ready = 1'b1;
        step();
        ch_valid = 2'b00;
        // Ready held into DRAIN must not produce a second pulse.
        #1;
        checks++; if (r_ch_ready !== 2'b00) begin errors++; $display("FAIL sp_drain_ready got=%0b exp=00", r_ch_ready); end
        axi_ready = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_op;
        do_reset();
        ch_addr[0 +: AW] = 64'h1000;
        ch_valid = 2'b01;
        step();
        checks++; if (r_grant !== 2'b01) begin errors++; $display("FAIL rm_grant0 got=%0b exp=01", r_grant); end
        rst = 1'b0;
        step();
        checks++; if (r_valid !== 1'b0 || r_grant !== 2'b00) begin errors++; $display("FAIL rm_reset got=%0h/%0b exp=0/00", r_valid, r_grant); end
        rst = 1'b1;
        ch_valid = 2'b10;
        ch_addr[1*AW +: AW] = 64'h4000;
        step();
        checks++; if (r_grant !== 2'b10 || r_valid !== 1'b1 || r_addr !== 64'h4000) begin errors++; $display("FAIL rm_ch1 got=%0b/%0h/%0h exp=10/1/4000", r_grant, r_valid, r_addr); end
        axi_ready = 1'b1;
        step();
        axi_ready = 1'b0;
        ch_valid = 2'b00;
        step();
    endtask

    initial begin
        rst = 1'b0;
        clear_inputs();
        test_reset();
        test_single_read();
        test_field_latch();    // leaves the RR pointer at 0 before the next reset
        test_rr_contention();
        test_fp_starvation();
        test_spurious_ready();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
